ram_sp_sync: RTL and testbench



---
 rtl/ram_pkg.sv | 32 +++
 rtl/ram_init_seq.sv | 64 ++++++
 rtl/ram_sp_sync.sv | 148 ++++++++++++++
 tb/tb_ram_sp_sync.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous single-port RAM.
// The FSM state type, the read-during-write encodings and the byte-lane merge live here.
package ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers size-cast in and out of it.
  localparam int MERGE_MAX_WIDTH = 512;
  localparam int MERGE_MAX_BYTES = MERGE_MAX_WIDTH / 8;

  function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
    input logic [MERGE_MAX_WIDTH-1:0] oldWord,
    input logic [MERGE_MAX_WIDTH-1:0] newWord,
    input logic [MERGE_MAX_BYTES-1:0] be
  );
    logic [MERGE_MAX_WIDTH-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MERGE_MAX_BYTES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset sequencer: holds the RAM busy while an optional clear pass zeroes
// every word, then hands the port over to the user by raising ready.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                stateNext;
  logic [ADDR_WIDTH-1:0] clrCount;
  logic [ADDR_WIDTH-1:0] clrCountNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      clrCount <= '0;
    end else begin
      state    <= stateNext;
      clrCount <= clrCountNext;
    end
  end

  // The clear pass writes one zero word per cycle and leaves INIT right after the last address.
  always_comb begin
    stateNext    = state;
    clrCountNext = clrCount;
    ready        = 1'b0;
    clr_we       = 1'b0;
    clr_addr     = clrCount;
    case (state)
      ST_INIT: begin
        if (INIT_CLEAR != 0) begin
          clr_we = 1'b1;
          if (clrCount == LAST_ADDR) begin
            stateNext    = ST_IDLE;
            clrCountNext = '0;
          end else begin
            clrCountNext = clrCount + ADDR_WIDTH'(1);
          end
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
      end
      default: begin
        stateNext = ST_INIT;
      end
    endcase
  end

endmodule

// File: rtl/ram_sp_sync.sv
// Synchronous single-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and an optional post-reset clear pass.
module ram_sp_sync
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    err,
  output logic                    ready
);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MERGE_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "ram_sp_sync: DATA_WIDTH must be a non-zero multiple of 8 no wider than the merge helper");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "ram_sp_sync: DEPTH must lie in 1 .. 2**ADDR_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "ram_sp_sync: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $fatal(1, "ram_sp_sync: RDW_MODE must be read-first or write-first");
  end

  localparam int                  AW1         = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = AW1'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clrWe;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  accept;
  logic                  inRange;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] oldWord;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [DATA_WIDTH-1:0] respData;

  ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clrWe),
    .clr_addr (clrAddr)
  );

  assign accept     = cs & ready;
  assign inRange    = {1'b0, addr} < DEPTH_LIMIT;
  assign oldWord    = inRange ? mem[addr] : '0;
  assign mergedWord = DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(oldWord),
                                             MERGE_MAX_WIDTH'(wdata),
                                             MERGE_MAX_BYTES'(be)));

  // ready is low for the whole clear pass, so the sequencer and the user never compete for the port.
  assign memWe    = clrWe | (accept & we & inRange);
  assign memAddr  = clrWe ? clrAddr : addr;
  assign memWdata = clrWe ? '0 : mergedWord;

  assign respData = !inRange                              ? '0         :
                    (we && RDW_MODE != RDW_READ_FIRST)    ? mergedWord :
                                                            oldWord;

  // The array has no reset: only the clear pass ever zeroes it.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memWdata;
    end
  end

  logic                  s0Valid;
  logic                  s0Err;
  logic [DATA_WIDTH-1:0] s0Data;
  logic                  s1Valid;
  logic                  s1Err;
  logic [DATA_WIDTH-1:0] s1Data;

  // s0 snapshots the response at the accepting edge; s1 presents it one cycle later and holds it between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0Valid <= 1'b0;
      s0Err   <= 1'b0;
      s0Data  <= '0;
      s1Valid <= 1'b0;
      s1Err   <= 1'b0;
      s1Data  <= '0;
    end else begin
      s0Valid <= accept;
      s0Err   <= accept & ~inRange;
      if (accept) begin
        s0Data <= respData;
      end
      s1Valid <= s0Valid;
      s1Err   <= s0Err;
      if (s0Valid) begin
        s1Data <= s0Data;
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rdata  = s1Data;
    assign rvalid = s1Valid;
    assign err    = s1Err;
  end else begin : g_lat2
    logic                  s2Valid;
    logic                  s2Err;
    logic [DATA_WIDTH-1:0] s2Data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2Valid <= 1'b0;
        s2Err   <= 1'b0;
        s2Data  <= '0;
      end else begin
        s2Valid <= s1Valid;
        s2Err   <= s1Err;
        if (s1Valid) begin
          s2Data <= s1Data;
        end
      end
    end

    assign rdata  = s2Data;
    assign rvalid = s2Valid;
    assign err    = s2Err;
  end

endmodule

// File: tb/tb_ram_sp_sync.sv
// Self-checking bench for ram_sp_sync: a byte-wide latency-1 read-first instance and a
// word-wide latency-2 write-first instance with DEPTH=12 share one stimulus stream.
module tb_ram_sp_sync;

  typedef struct {
    logic        cs;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        expValid;
    logic [7:0]  expData;
    logic        expErr;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] wdata;

  logic [7:0]  rdata8;
  logic        rvalid8;
  logic        err8;
  logic        ready8;
  logic [31:0] rdata32;
  logic        rvalid32;
  logic        err32;
  logic        ready32;

  int          checks;
  int          errors;
  int          cycle;
  int          relEdges [2];
  int          pulseCount [2];
  logic [31:0] lastData [2];
  logic [31:0] modelMem [2][16];
  resp_t       q0 [$];
  resp_t       q1 [$];
  vec_t        vecs [12];

  ram_sp_sync #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .RD_LATENCY (1),
    .RDW_MODE   (0),
    .INIT_CLEAR (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .be     (be[0:0]),
    .addr   (addr),
    .wdata  (wdata[7:0]),
    .rdata  (rdata8),
    .rvalid (rvalid8),
    .err    (err8),
    .ready  (ready8)
  );

  ram_sp_sync #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32),
    .DEPTH      (12),
    .RD_LATENCY (2),
    .RDW_MODE   (1),
    .INIT_CLEAR (1)
  ) dut2 (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .be     (be),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata32),
    .rvalid (rvalid32),
    .err    (err32),
    .ready  (ready32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depthOf(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] maskOf(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  task automatic checkEq(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d) at cycle %0d: got 0x%h, expected 0x%h", name, k, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [3:0] b,
                               input logic [3:0] a, input logic [31:0] d);
    cs    = c;
    we    = w;
    be    = b;
    addr  = a;
    wdata = d;
  endtask

  // Reference model: a word array per instance and a queue of responses due at a given cycle.
  task automatic modelAccess(input int k);
    resp_t       r;
    logic [31:0] mask;
    logic [31:0] oldW;
    logic [31:0] newW;
    r.due = cycle + latOf(k);
    if (int'(addr) >= depthOf(k)) begin
      r.data = 32'h0;
      r.err  = 1'b1;
    end else begin
      oldW = modelMem[k][addr];
      mask = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mask = mask | (32'hFF << (8 * b));
      end
      mask = mask & maskOf(k);
      newW = ((oldW & ~mask) | (wdata & mask)) & maskOf(k);
      if (we) modelMem[k][addr] = newW;
      r.data = (we && k == 1) ? newW : oldW;
      r.err  = 1'b0;
    end
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic modelEdge();
    cycle++;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        if (relEdges[k] >= depthOf(k) && cs) modelAccess(k);
        relEdges[k]++;
      end
    end
  endtask

  task automatic checkDut(input int k, input logic [31:0] od, input logic ov, input logic oe, input logic ordy);
    resp_t r;
    logic  expValid;
    logic  expErr;
    logic  expReady;
    expValid = 1'b0;
    expErr   = 1'b0;
    r.due    = 0;
    r.data   = 32'h0;
    r.err    = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cycle) begin r = q0.pop_front(); expValid = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cycle) begin r = q1.pop_front(); expValid = 1'b1; end
    end
    if (expValid) begin
      expErr      = r.err;
      lastData[k] = r.data;
    end
    expReady = !rst && (relEdges[k] >= depthOf(k));
    checkEq("ready", k, {31'h0, ordy}, {31'h0, expReady});
    checkEq("rvalid", k, {31'h0, ov}, {31'h0, expValid});
    checkEq("err", k, {31'h0, oe}, {31'h0, expErr});
    checkEq("rdata", k, od, lastData[k]);
    if (ov === 1'b1) pulseCount[k]++;
  endtask

  task automatic checkOutput();
    checkDut(0, {24'h0, rdata8}, rvalid8, err8, ready8);
    checkDut(1, rdata32, rvalid32, err32, ready32);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idleSteps(input int n);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    repeat (n) step();
  endtask

  task automatic doReset(input int hold);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    #1;
    checkEq("rst_rvalid", 0, {31'h0, rvalid8}, 32'h0);
    checkEq("rst_err", 0, {31'h0, err8}, 32'h0);
    checkEq("rst_rdata", 0, {24'h0, rdata8}, 32'h0);
    checkEq("rst_ready", 0, {31'h0, ready8}, 32'h0);
    checkEq("rst_rvalid", 1, {31'h0, rvalid32}, 32'h0);
    checkEq("rst_err", 1, {31'h0, err32}, 32'h0);
    checkEq("rst_rdata", 1, rdata32, 32'h0);
    checkEq("rst_ready", 1, {31'h0, ready32}, 32'h0);
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      relEdges[k] = 0;
      lastData[k] = 32'h0;
      for (int a = 0; a < 16; a++) modelMem[k][a] = 32'h0;
    end
    repeat (hold) step();
    rst = 1'b0;
  endtask

  // Runs the clear pass with random read requests (which must be ignored) and times the rise of ready.
  task automatic initPhase();
    int rise0;
    int rise1;
    rise0 = 0;
    rise1 = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 4'hF, 4'($urandom_range(0, 15)), $urandom);
      step();
      if (rise0 == 0 && ready8 === 1'b1) rise0 = i;
      if (rise1 == 0 && ready32 === 1'b1) rise1 = i;
    end
    checkEq("ready_rise_cycles", 0, rise0, 16);
    checkEq("ready_rise_cycles", 1, rise1, 12);
    idleSteps(3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    rst    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      relEdges[k]   = 0;
      pulseCount[k] = 0;
      lastData[k]   = 32'h0;
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

    vecs[0]  = '{1'b1, 1'b1, 4'hF, 4'd3,  32'h0000_00A5, 1'b1, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'd3,  32'h0000_0000, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 4'd3,  32'h0000_005A, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'd3,  32'h0000_0000, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'd0,  32'h0000_0000, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'hF, 4'd15, 32'h0000_003C, 1'b1, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'd15, 32'h0000_0000, 1'b1, 8'h3C, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'hF, 4'd3,  32'h0000_0077, 1'b1, 8'hA5, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'd3,  32'h0000_0000, 1'b1, 8'h77, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'd0,  32'h0000_0000, 1'b1, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'h1, 4'd0,  32'h0000_00FF, 1'b1, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 4'd0,  32'h0000_0000, 1'b1, 8'hFF, 1'b0};

    #2;
    doReset(2);
    initPhase();

    begin : b2b_reads
      int p0;
      p0 = pulseCount[0];
      for (int a = 0; a < 16; a++) begin
        applyStimulus(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
        step();
      end
      idleSteps(3);
      checkEq("b2b_pulse_count", 0, pulseCount[0] - p0, 16);
    end

    for (int i = 0; i <= 12; i++) begin
      if (i < 12) applyStimulus(vecs[i].cs, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      else        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      step();
      if (i > 0) begin
        checkEq($sformatf("vec%0d_rvalid", i - 1), 0, {31'h0, rvalid8}, {31'h0, vecs[i-1].expValid});
        checkEq($sformatf("vec%0d_rdata", i - 1), 0, {24'h0, rdata8}, {24'h0, vecs[i-1].expData});
        checkEq($sformatf("vec%0d_err", i - 1), 0, {31'h0, err8}, {31'h0, vecs[i-1].expErr});
      end
    end
    idleSteps(3);

    applyStimulus(1'b1, 1'b1, 4'hF, 4'd3, 32'h0000_00A5);
    step();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    checkEq("wr_then_rd_valid", 0, {31'h0, rvalid8}, 32'h1);
    checkEq("wr_then_rd_data", 0, {24'h0, rdata8}, 32'hA5);
    step();
    checkEq("wr_then_rd_valid", 1, {31'h0, rvalid32}, 32'h1);
    checkEq("wr_then_rd_data", 1, rdata32, 32'h0000_00A5);
    idleSteps(3);

    applyStimulus(1'b1, 1'b1, 4'hF, 4'd5, 32'h1122_3344);
    step();
    applyStimulus(1'b1, 1'b1, 4'b0101, 4'd5, 32'hAABB_CCDD);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    checkEq("merge_write_resp_read_first", 0, {24'h0, rdata8}, 32'h44);
    step();
    checkEq("merge_write_resp_write_first", 1, rdata32, 32'h11BB_33DD);
    idleSteps(2);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    step();
    idleSteps(2);
    checkEq("merge_read_valid", 1, {31'h0, rvalid32}, 32'h1);
    checkEq("merge_read_data", 1, rdata32, 32'h11BB_33DD);
    idleSteps(3);

    applyStimulus(1'b1, 1'b1, 4'hF, 4'd13, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    checkEq("oob_write_err", 1, {31'h0, err32}, 32'h1);
    checkEq("oob_write_data", 1, rdata32, 32'h0);
    step();
    checkEq("oob_read_err", 1, {31'h0, err32}, 32'h1);
    checkEq("oob_read_data", 1, rdata32, 32'h0);
    idleSteps(3);
    for (int a = 0; a < 12; a++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
      step();
    end
    idleSteps(3);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    4'($urandom), 4'($urandom), $urandom);
      step();
    end
    idleSteps(4);

    applyStimulus(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    step();
    checkEq("pre_reset_rvalid", 1, {31'h0, rvalid32}, 32'h1);
    doReset(3);
    initPhase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
